// File: rtl/surv_ram_sched_pkg.sv
// Shared types and default widths for the survivor-RAM scheduler.
// Width defines normally arrive from the shared params.v; the guarded fallbacks only cover standalone builds.
`ifndef WD_DEPTH
`define WD_DEPTH 2
`endif
`ifndef WD_RAM_ADDRESS
`define WD_RAM_ADDRESS 5
`endif
`ifndef WD_RAM_DATA
`define WD_RAM_DATA 8
`endif

package surv_ram_sched_pkg;

  localparam int WD_PAGE_DEF = `WD_DEPTH;
  localparam int WD_SEG_DEF  = `WD_RAM_ADDRESS - `WD_DEPTH;
  localparam int WD_DATA_DEF = `WD_RAM_DATA;

  // One-hot grant from the two-requester arbiter: bit 0 write, bit 1 read.
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_WR   = 2'b01,
    GNT_RD   = 2'b10
  } gnt_e;

  typedef enum logic {
    WIN_WR = 1'b0,
    WIN_RD = 1'b1
  } winner_e;

endpackage

// File: rtl/surv_ram_sched_if.sv
// ACS write / traceback read / release handshake bundle for surv_ram_sched.
// The scheduler sits on the slave side; the datapath driving requests is the master.
interface surv_ram_sched_if #(
  parameter int WD_PAGE = surv_ram_sched_pkg::WD_PAGE_DEF,
  parameter int WD_SEG  = surv_ram_sched_pkg::WD_SEG_DEF,
  parameter int WD_DATA = surv_ram_sched_pkg::WD_DATA_DEF
);
  logic               wr_req;
  logic               wr_last;
  logic [WD_SEG-1:0]  wr_seg;
  logic [WD_DATA-1:0] wr_data;
  logic               wr_gnt;
  logic               rd_req;
  logic [WD_PAGE-1:0] rd_page;
  logic [WD_SEG-1:0]  rd_seg;
  logic               rd_gnt;
  logic               rd_valid;
  logic [WD_DATA-1:0] rd_data;
  logic               tb_release;

  modport master (
    output wr_req, wr_last, wr_seg, wr_data, rd_req, rd_page, rd_seg, tb_release,
    input  wr_gnt, rd_gnt, rd_valid, rd_data
  );

  modport slave (
    input  wr_req, wr_last, wr_seg, wr_data, rd_req, rd_page, rd_seg, tb_release,
    output wr_gnt, rd_gnt, rd_valid, rd_data
  );
endinterface

// File: rtl/surv_ram_sched_arb2.sv
// surv_arb2: two-requester arbiter for the survivor RAM port (write vs traceback read).
// SURV_RR_ARB_EN selects round-robin between simultaneous requests; otherwise write always wins.
module surv_arb2
  import surv_ram_sched_pkg::*;
(
`ifdef SURV_RR_ARB_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic wr_elig,
  input  logic rd_elig,
  output gnt_e gnt
);

`ifdef SURV_RR_ARB_EN
  winner_e last_q, last_d;

  always_comb begin
    gnt    = GNT_NONE;
    last_d = last_q;
    if (wr_elig && rd_elig) gnt = (last_q == WIN_RD) ? GNT_WR : GNT_RD;
    else if (wr_elig)       gnt = GNT_WR;
    else if (rd_elig)       gnt = GNT_RD;
    if (gnt == GNT_WR) last_d = WIN_WR;
    if (gnt == GNT_RD) last_d = WIN_RD;
  end

  // Starting from "read won last" lets the first contested cycle go to the writer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= WIN_RD;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    gnt = GNT_NONE;
    if (wr_elig)      gnt = GNT_WR;
    else if (rd_elig) gnt = GNT_RD;
  end
`endif

endmodule

// File: rtl/surv_ram_sched.sv
// Survivor-memory scheduler: pages a single-port RAM between ACS writes and traceback reads.
// Optional macro SURV_RR_ARB_EN switches the port arbiter from write-priority to round-robin.
module surv_ram_sched
  import surv_ram_sched_pkg::*;
#(
  parameter int WD_PAGE = `WD_DEPTH,
  parameter int WD_SEG  = `WD_RAM_ADDRESS - `WD_DEPTH,
  parameter int WD_DATA = `WD_RAM_DATA
) (
  input  logic                      CLOCK,
  input  logic                      Reset,
  input  logic                      Active,
  input  logic                      Hold,
  surv_ram_sched_if.slave           acs,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [WD_PAGE+WD_SEG-1:0] ram_addr,
  output logic [WD_DATA-1:0]        ram_wdata,
  input  logic [WD_DATA-1:0]        ram_rdata,
  output logic [WD_PAGE-1:0]        wr_page,
  output logic [WD_PAGE-1:0]        oldest_page,
  output logic [WD_PAGE-1:0]        newest_page,
  output logic [WD_PAGE:0]          full_cnt,
  output logic                      err
);

  localparam logic [WD_PAGE:0]   CNT_FULL = {1'b1, {WD_PAGE{1'b0}}};
  localparam logic [WD_PAGE:0]   CNT_ONE  = (WD_PAGE+1)'(1);
  localparam logic [WD_PAGE-1:0] PAGE_ONE = WD_PAGE'(1);

  logic [WD_PAGE-1:0] wr_page_q, wr_page_d;
  logic [WD_PAGE-1:0] oldest_q, oldest_d;
  logic [WD_PAGE:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               rd_valid_q, rd_valid_d;
  logic               wr_elig, rd_elig, page_done, release_ok;
  gnt_e               gnt;

  // Reset gates eligibility so an access in flight at reset never reaches the RAM.
  assign wr_elig = acs.wr_req & Active & ~Hold & ~Reset & (cnt_q != CNT_FULL);
  assign rd_elig = acs.rd_req & Active & ~Hold & ~Reset & (cnt_q != '0);

  surv_arb2 u_arb (
`ifdef SURV_RR_ARB_EN
    .clk     (CLOCK),
    .rst     (Reset),
`endif
    .wr_elig (wr_elig),
    .rd_elig (rd_elig),
    .gnt     (gnt)
  );

  assign acs.wr_gnt   = (gnt == GNT_WR);
  assign acs.rd_gnt   = (gnt == GNT_RD);
  assign acs.rd_valid = rd_valid_q;
  assign acs.rd_data  = ram_rdata;

  assign ram_en    = acs.wr_gnt | acs.rd_gnt;
  assign ram_we    = acs.wr_gnt;
  assign ram_addr  = acs.wr_gnt ? {wr_page_q, acs.wr_seg} : {acs.rd_page, acs.rd_seg};
  assign ram_wdata = acs.wr_data;

  assign wr_page     = wr_page_q;
  assign oldest_page = oldest_q;
  assign newest_page = wr_page_q - PAGE_ONE;
  assign full_cnt    = cnt_q;
  assign err         = err_q;

  assign page_done  = acs.wr_gnt & acs.wr_last;
  assign release_ok = acs.tb_release & (cnt_q != '0);

  always_comb begin
    wr_page_d  = wr_page_q;
    oldest_d   = oldest_q;
    cnt_d      = cnt_q;
    err_d      = err_q | (acs.tb_release & (cnt_q == '0));
    rd_valid_d = acs.rd_gnt;
    if (page_done)  wr_page_d = wr_page_q + PAGE_ONE;
    if (release_ok) oldest_d  = oldest_q + PAGE_ONE;
    // Simultaneous completion and release cancel in the occupancy count.
    case ({page_done, release_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      wr_page_q  <= '0;
      oldest_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_page_q  <= wr_page_d;
      oldest_q   <= oldest_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_surv_ram_sched.sv
// Self-checking bench for surv_ram_sched: page-level scoreboard checked every falling edge,
// plus directed scenarios with hand-computed literals. Honours SURV_RR_ARB_EN if defined.
module tb_surv_ram_sched;
  import surv_ram_sched_pkg::*;

  localparam int WP  = WD_PAGE_DEF;
  localparam int WS  = WD_SEG_DEF;
  localparam int WDD = WD_DATA_DEF;
  localparam int NP  = 1 << WP;
  localparam int WA  = WP + WS;

  logic CLOCK = 1'b0;
  logic Reset, Active, Hold;
  logic           ram_en, ram_we;
  logic [WA-1:0]  ram_addr;
  logic [WDD-1:0] ram_wdata, ram_rdata;
  logic [WP-1:0]  wr_page, oldest_page, newest_page;
  logic [WP:0]    full_cnt;
  logic           err;

  surv_ram_sched_if acs ();

  surv_ram_sched dut (
    .CLOCK       (CLOCK),
    .Reset       (Reset),
    .Active      (Active),
    .Hold        (Hold),
    .acs         (acs),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .wr_page     (wr_page),
    .oldest_page (oldest_page),
    .newest_page (newest_page),
    .full_cnt    (full_cnt),
    .err         (err)
  );

  always #5 CLOCK = ~CLOCK;

  // Environment: single-port synchronous RAM.
  logic [WDD-1:0] ram_mem [0:(1<<WA)-1];
  always @(posedge CLOCK) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: page ring as plain integers plus a shadow memory.
  int             m_wp, m_op, m_cnt;
  bit             m_err, m_pend;
  logic [WDD-1:0] m_pdata;
  logic [WDD-1:0] m_mem [0:(1<<WA)-1];
`ifdef SURV_RR_ARB_EN
  bit             m_lw_rd;
`endif

  always @(negedge CLOCK) begin : compare
    bit wr_ok, rd_ok, e_wr, e_rd, rel;
    int a_wr, a_rd;
    if (Reset) begin
      m_wp = 0; m_op = 0; m_cnt = 0; m_err = 0; m_pend = 0;
`ifdef SURV_RR_ARB_EN
      m_lw_rd = 1;
`endif
    end
    wr_ok = !Reset && acs.wr_req && Active && !Hold && (m_cnt < NP);
    rd_ok = !Reset && acs.rd_req && Active && !Hold && (m_cnt > 0);
`ifdef SURV_RR_ARB_EN
    e_wr = wr_ok && (!rd_ok || m_lw_rd);
`else
    e_wr = wr_ok;
`endif
    e_rd = rd_ok && !e_wr;
    a_wr = m_wp * (1 << WS) + int'(acs.wr_seg);
    a_rd = int'(acs.rd_page) * (1 << WS) + int'(acs.rd_seg);

    chk("wr_gnt", 32'(acs.wr_gnt), 32'(e_wr));
    chk("rd_gnt", 32'(acs.rd_gnt), 32'(e_rd));
    chk("ram_en", 32'(ram_en), 32'(e_wr || e_rd));
    chk("ram_we", 32'(ram_we), 32'(e_wr));
    if (e_wr) begin
      chk("ram_addr_wr", 32'(ram_addr), a_wr);
      chk("ram_wdata", 32'(ram_wdata), 32'(acs.wr_data));
    end
    if (e_rd) chk("ram_addr_rd", 32'(ram_addr), a_rd);
    chk("rd_valid", 32'(acs.rd_valid), 32'(m_pend));
    if (m_pend) chk("rd_data", 32'(acs.rd_data), 32'(m_pdata));
    chk("wr_page", 32'(wr_page), m_wp);
    chk("oldest_page", 32'(oldest_page), m_op);
    chk("full_cnt", 32'(full_cnt), m_cnt);
    chk("err", 32'(err), 32'(m_err));
    if (m_cnt != 0) chk("newest_page", 32'(newest_page), (m_wp + NP - 1) % NP);

    if (!Reset) begin
      if (e_wr) m_mem[a_wr] = acs.wr_data;
      m_pend = e_rd;
      if (e_rd) m_pdata = m_mem[a_rd];
`ifdef SURV_RR_ARB_EN
      if (e_wr || e_rd) m_lw_rd = e_rd;
`endif
      rel = acs.tb_release && (m_cnt > 0);
      if (acs.tb_release && m_cnt == 0) m_err = 1;
      if (e_wr && acs.wr_last) begin m_wp = (m_wp + 1) % NP; m_cnt++; end
      if (rel) begin m_op = (m_op + 1) % NP; m_cnt--; end
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle();
    acs.wr_req = 0; acs.wr_last = 0; acs.rd_req = 0; acs.tb_release = 0;
  endtask

  task automatic wr(input int seg, input int data, input bit last);
    acs.wr_req = 1; acs.wr_seg = WS'(seg); acs.wr_data = WDD'(data); acs.wr_last = last;
  endtask

  task automatic rd(input int page, input int seg);
    acs.rd_req = 1; acs.rd_page = WP'(page); acs.rd_seg = WS'(seg);
  endtask

  initial begin
    int nw, nr;
    bit exp_w;
    Reset = 1; Active = 0; Hold = 0;
    idle();
    acs.wr_seg = '0; acs.wr_data = '0; acs.rd_page = '0; acs.rd_seg = '0;
    acs.wr_req = 1;
    tick();
    chk("rst_wr_gnt", 32'(acs.wr_gnt), 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_newest", 32'(newest_page), NP - 1);
    chk("rst_full_cnt", 32'(full_cnt), 0);
    tick();
    Reset = 0; Active = 1; idle();

    // First page: segments 0..3, data A0..A3
    for (int s = 0; s < 4; s++) begin
      wr(s, 'hA0 + s, s == 3);
      #1;
      chk("p0_wr_gnt", 32'(acs.wr_gnt), 1);
      chk("p0_addr", 32'(ram_addr), s);
      tick();
    end
    idle();
    chk("p0_wr_page", 32'(wr_page), 1);
    chk("p0_full_cnt", 32'(full_cnt), 1);
    chk("p0_newest", 32'(newest_page), 0);

    rd(0, 2);
    #1;
    chk("rd_gnt_p0s2", 32'(acs.rd_gnt), 1);
    tick();
    idle();
    chk("rd_valid_p0s2", 32'(acs.rd_valid), 1);
    chk("rd_data_p0s2", 32'(acs.rd_data), 'hA2);
    tick();

    // Fill the remaining pages
    for (int p = 1; p < NP; p++)
      for (int s = 0; s < 4; s++) begin
        wr(s, p * 16 + s, s == 3);
        tick();
      end
    idle();
    wr(0, 'h55, 0);
    #1;
    chk("full_cnt_max", 32'(full_cnt), NP);
    chk("stall_gnt", 32'(acs.wr_gnt), 0);
    tick();
    chk("stall_gnt2", 32'(acs.wr_gnt), 0);
    acs.tb_release = 1;
    tick();
    acs.tb_release = 0;
    chk("rel_full_cnt", 32'(full_cnt), NP - 1);
    chk("rel_oldest", 32'(oldest_page), 1);
    chk("rel_wr_gnt", 32'(acs.wr_gnt), 1);
    tick();
    idle();

    rd(1, 1);
    tick();
    rd(3, 3);
    tick();
    rd(0, 0);
    chk("rd_data_p3s3", 32'(acs.rd_data), 'h33);
    tick();
    idle();
    chk("rd_data_p0s0", 32'(acs.rd_data), 'h55);
    tick();

    // Contention: write and read requested together for four cycles
    nw = 0; nr = 0;
    for (int i = 0; i < 4; i++) begin
      wr(1 + i, 'hC0 + i, 0);
      rd(1, 0);
      #1;
`ifdef SURV_RR_ARB_EN
      exp_w = (i % 2 == 0);
`else
      exp_w = 1;
`endif
      chk("arb_seq", 32'(acs.wr_gnt), 32'(exp_w));
      nw += int'(acs.wr_gnt);
      nr += int'(acs.rd_gnt);
      tick();
    end
    idle();
`ifdef SURV_RR_ARB_EN
    chk("arb_writes", nw, 2);
    chk("arb_reads", nr, 2);
`else
    chk("arb_writes", nw, 4);
    chk("arb_reads", nr, 0);
`endif
    tick();

    // Page completion and release in the same cycle
    wr(5, 'hD5, 1);
    acs.tb_release = 1;
    tick();
    idle();
    chk("both_full_cnt", 32'(full_cnt), 3);
    chk("both_wr_page", 32'(wr_page), 1);
    chk("both_oldest", 32'(oldest_page), 2);

    for (int i = 0; i < 3; i++) begin
      acs.tb_release = 1;
      tick();
    end
    idle();
    chk("drain_full_cnt", 32'(full_cnt), 0);
    chk("drain_oldest", 32'(oldest_page), 1);
    rd(0, 0);
    #1;
    chk("empty_rd_gnt", 32'(acs.rd_gnt), 0);
    idle();
    acs.tb_release = 1;
    tick();
    acs.tb_release = 0;
    chk("err_set", 32'(err), 1);
    chk("err_full_cnt", 32'(full_cnt), 0);
    chk("err_oldest", 32'(oldest_page), 1);
    chk("err_wr_page", 32'(wr_page), 1);
    tick();
    tick();
    chk("err_sticky", 32'(err), 1);

    // One more page so reads are eligible, then Hold / Active gating
    for (int s = 0; s < 4; s++) begin
      wr(s, 'hE0 + s, s == 3);
      tick();
    end
    idle();
    Hold = 1;
    wr(0, 'h77, 0);
    rd(1, 2);
    #1;
    chk("hold_wr_gnt", 32'(acs.wr_gnt), 0);
    chk("hold_rd_gnt", 32'(acs.rd_gnt), 0);
    chk("hold_ram_en", 32'(ram_en), 0);
    tick();
    tick();
    Hold = 0; Active = 0;
    #1;
    chk("inactive_ram_en", 32'(ram_en), 0);
    tick();
    Active = 1;
    idle();

    // Reset pulsed while a read is being granted
    rd(1, 2);
    #1;
    chk("pre_rst_rd_gnt", 32'(acs.rd_gnt), 1);
    #1;
    Reset = 1;
    #1;
    chk("mid_rst_rd_gnt", 32'(acs.rd_gnt), 0);
    chk("mid_rst_wr_page", 32'(wr_page), 0);
    chk("mid_rst_err", 32'(err), 0);
    idle();
    tick();
    Reset = 0;
    #1;
    chk("post_rst_rd_valid", 32'(acs.rd_valid), 0);
    chk("post_rst_oldest", 32'(oldest_page), 0);
    chk("post_rst_full_cnt", 32'(full_cnt), 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/surv_ram_sched.md
SURV_RAM_SCHED -- requirements
Module: surv_ram_sched

Interface
REQ-001 Parameter WD_PAGE, default `WD_DEPTH`, page-index width; N_PAGES = 2**WD_PAGE.
REQ-002 Parameter WD_SEG, default `WD_RAM_ADDRESS`-`WD_DEPTH`, segment-within-page width.
REQ-003 Parameter WD_DATA, default `WD_RAM_DATA`, RAM word width.
REQ-004 CLOCK  in  1  sole clock, all state on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Active, Hold  in  1 each  Active low or Hold high blocks all grants; state is retained.
REQ-007 wr_req, wr_last  in  1 each; wr_seg  in  WD_SEG; wr_data  in  WD_DATA  ACS write request; wr_last marks the final segment of a page.
REQ-008 wr_gnt  out  1  write accepted this cycle.
REQ-009 rd_req  in  1; rd_page  in  WD_PAGE; rd_seg  in  WD_SEG  traceback read request.
REQ-010 rd_gnt  out  1; rd_valid  out  1; rd_data  out  WD_DATA  read grant, and data one cycle later.
REQ-011 tb_release  in  1  one-cycle pulse that frees the oldest full page.
REQ-012 ram_en, ram_we  out  1 each; ram_addr  out  WD_PAGE+WD_SEG; ram_wdata  out  WD_DATA; ram_rdata  in  WD_DATA  single-port synchronous RAM port.
REQ-013 wr_page, oldest_page, newest_page  out  WD_PAGE; full_cnt  out  WD_PAGE+1; err  out  1.

Function
REQ-014 At most one RAM access per cycle: ram_en = wr_gnt | rd_gnt, ram_we = wr_gnt.
REQ-015 On a write grant, ram_addr = {wr_page, wr_seg} and ram_wdata = wr_data; on a read grant, ram_addr = {rd_page, rd_seg}.
REQ-016 Grants are combinational from the current requests and registered state.
REQ-017 Write is eligible when wr_req & Active & !Hold & full_cnt < N_PAGES.
REQ-018 Read is eligible when rd_req & Active & !Hold & full_cnt != 0.
REQ-019 Arbitration with both eligible: write wins (default build).
REQ-020 rd_valid is asserted exactly one cycle after rd_gnt; rd_data = ram_rdata in that cycle.
REQ-021 When wr_gnt & wr_last: wr_page increments mod N_PAGES and full_cnt increments.
REQ-022 When tb_release & full_cnt != 0: oldest_page increments mod N_PAGES and full_cnt decrements.
REQ-023 Page completion and release in the same cycle: full_cnt unchanged; both pointers advance.
REQ-024 newest_page = wr_page-1 mod N_PAGES; its value is meaningful only when full_cnt != 0.
REQ-025 full_cnt == N_PAGES stalls writes: wr_gnt stays low until a release.
REQ-026 tb_release with full_cnt == 0 is ignored and sets err.
REQ-027 err is sticky until Reset.

Reset
REQ-028 Reset asynchronously clears wr_page, oldest_page, full_cnt, err, rd_valid, the arbiter state and the rd_valid pipeline.
REQ-029 During reset: all grants and ram_en are 0, and newest_page = N_PAGES-1.
REQ-030 Reset asserted mid-access drops that access; no pointer updates for it.

Configuration
REQ-031 Macro SURV_RR_ARB_EN: when defined, simultaneous eligible requests alternate, round-robin on a last_winner flop (reset value = read, so write wins first).
REQ-032 When SURV_RR_ARB_EN is undefined, fixed write priority applies and no last_winner flop exists.

Structure
REQ-033 Width defines WD_DEPTH, WD_RAM_ADDRESS and WD_RAM_DATA come from shared params.v; no local redefinition.
REQ-034 The two-requester arbiter is sub-module surv_arb2 (inputs: eligibility flags; outputs: one-hot grant); it holds the SURV_RR_ARB_EN logic.

Verification
REQ-035 Reset release, Active=1, 4 writes seg 0..3 with wr_last on seg 3, data 0xA0..0xA3 -> wr_gnt each cycle; ram_addr {0,0..3}; wr_page=1, full_cnt=1, newest_page=0.
REQ-036 Read page 0 seg 2 after REQ-035 -> rd_gnt, then next cycle rd_valid=1 and rd_data=0xA2.
REQ-037 Fill all N_PAGES pages without release -> full_cnt=N_PAGES and wr_gnt held low; one tb_release -> full_cnt=N_PAGES-1, write proceeds next cycle, oldest_page=1.
REQ-038 Simultaneous wr_req+rd_req for 4 cycles -> default build: 4 writes, 0 reads; SURV_RR_ARB_EN build: grants W,R,W,R.
REQ-039 tb_release at full_cnt=0 -> err=1 and stays set, counters unchanged.
REQ-040 Reset pulsed during a read grant -> rd_valid=0 next cycle, all pointers 0, err=0; Hold=1 with requests -> no grants and ram_en=0.
